mem_write_checker: RTL and testbench

//  Synthesizable self-checking monitor for the multicycle core's data-memory write port.

---
 rtl/mem_write_checker.sv | 172 +++++++++++++++++
 tb/tb_mem_write_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the core's data-memory write port: compares observed writes
// against a loadable table of expected (adr,data) pairs and holds a sticky pass/fail verdict.
module mem_write_checker #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int NCHK    = 4,
    parameter int TIMEOUT = 4096,
    parameter int ORDERED = 1,
    localparam int IW     = (NCHK > 1) ? $clog2(NCHK) : 1,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] writedata,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [AW-1:0] exp_adr,
    input  logic [DW-1:0] exp_data,
    input  logic          start,
    output logic          pass,
    output logic          fail,
    output logic          done,
    output logic [1:0]    fail_code,
    output logic [IW:0]   match_cnt,
    output logic [15:0]   write_cnt,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   tab_adr_r  [NCHK];
    logic [DW-1:0]   tab_data_r [NCHK];
    logic [NCHK-1:0] hit_r;
    logic [IW:0]     match_cnt_r;
    logic [15:0]     write_cnt_r;
    logic [TW-1:0]   timer_r;
    logic            pass_r;
    logic            fail_r;
    logic            done_r;
    logic [1:0]      fail_code_r;
    logic [AW-1:0]   fail_adr_r;
    logic [DW-1:0]   fail_data_r;

    logic [IW-1:0]   ptr_s;
    logic            ord_adr_s;
    logic            ord_data_s;
    logic [NCHK-1:0] full_hit_s;
    logic [NCHK-1:0] adr_hit_s;
    logic [IW-1:0]   full_idx_s;
    logic            match_s;
    logic            mismatch_s;
    logic            last_s;
    logic            timeout_s;
    logic            idx_ok_s;

    // Compare the sampled write against the table (ordered pointer and unordered search)
    always_comb begin
        ptr_s      = match_cnt_r[IW-1:0];
        ord_adr_s  = (adr == tab_adr_r[ptr_s]);
        ord_data_s = (writedata == tab_data_r[ptr_s]);
        full_hit_s = '0;
        adr_hit_s  = '0;
        full_idx_s = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            adr_hit_s[i]  = !hit_r[i] && (adr == tab_adr_r[i]);
            full_hit_s[i] = adr_hit_s[i] && (writedata == tab_data_r[i]);
            // descending scan so the lowest matching index is the one left behind
            full_idx_s    = full_hit_s[i] ? IW'(i) : full_idx_s;
        end
        match_s    = memwrite && ((ORDERED != 0) ? (ord_adr_s && ord_data_s) : (|full_hit_s));
        mismatch_s = memwrite && ((ORDERED != 0) ? (ord_adr_s && !ord_data_s)
                                                 : ((|adr_hit_s) && !(|full_hit_s)));
        last_s     = match_s && (match_cnt_r == (IW+1)'(NCHK - 1));
        timeout_s  = (timer_r == TW'(TIMEOUT - 1));
        idx_ok_s   = ({1'b0, exp_idx} < (IW+1)'(NCHK));
    end

    // FSM, expected-write table, run counters and registered verdict
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            hit_r       <= '0;
            match_cnt_r <= '0;
            write_cnt_r <= 16'h0000;
            timer_r     <= '0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_code_r <= 2'd0;
            fail_adr_r  <= '0;
            fail_data_r <= '0;
            for (int i = 0; i < NCHK; i++) begin
                tab_adr_r[i]  <= '0;
                tab_data_r[i] <= '0;
            end
        end else begin
            if (exp_we && (state_r != ST_RUN) && idx_ok_s) begin
                tab_adr_r[exp_idx]  <= exp_adr;
                tab_data_r[exp_idx] <= exp_data;
            end
            case (state_r)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        hit_r       <= '0;
                        match_cnt_r <= '0;
                        write_cnt_r <= 16'h0000;
                        timer_r     <= '0;
                        pass_r      <= 1'b0;
                        fail_r      <= 1'b0;
                        done_r      <= 1'b0;
                        fail_code_r <= 2'd0;
                        fail_adr_r  <= '0;
                        fail_data_r <= '0;
                    end
                end
                ST_RUN: begin
                    timer_r <= timer_r + TW'(1);
                    if (memwrite && (write_cnt_r != 16'hFFFF)) begin
                        write_cnt_r <= write_cnt_r + 16'd1;
                    end
                    if (match_s) begin
                        match_cnt_r <= match_cnt_r + (IW+1)'(1);
                        if (ORDERED == 0) begin
                            hit_r[full_idx_s] <= 1'b1;
                        end
                    end
                    // a completing match beats both a mismatch and the timeout
                    if (last_s) begin
                        state_r <= ST_PASS;
                        pass_r  <= 1'b1;
                        done_r  <= 1'b1;
                    end else if (mismatch_s) begin
                        state_r     <= ST_FAIL;
                        fail_r      <= 1'b1;
                        done_r      <= 1'b1;
                        fail_code_r <= 2'd1;
                        fail_adr_r  <= adr;
                        fail_data_r <= writedata;
                    end else if (timeout_s) begin
                        state_r     <= ST_FAIL;
                        fail_r      <= 1'b1;
                        done_r      <= 1'b1;
                        fail_code_r <= 2'd2;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pass      = pass_r;
    assign fail      = fail_r;
    assign done      = done_r;
    assign fail_code = fail_code_r;
    assign match_cnt = match_cnt_r;
    assign write_cnt = write_cnt_r;
    assign fail_adr  = fail_adr_r;
    assign fail_data = fail_data_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: three checker instances (ordered/2, unordered/2, single/1 entry, TIMEOUT=16)
// share one stimulus stream; expected verdicts are queued per instance and popped by a monitor.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic        exp_we;
    logic [0:0]  exp_idx;
    logic [15:0] exp_adr;
    logic [15:0] exp_data;
    logic        start;
    logic        snap;

    logic        pass_w  [3];
    logic        fail_w  [3];
    logic        done_w  [3];
    logic [1:0]  code_w  [3];
    logic [1:0]  mcnt_w  [3];
    logic [15:0] wcnt_w  [3];
    logic [15:0] fadr_w  [3];
    logic [15:0] fdata_w [3];

    typedef struct {
        int p;
        int f;
        int code;
        int mcnt;
        int wcnt;
        int fadr;
        int fdata;
        int at;
    } rec_t;

    rec_t exp_q [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done_prev [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_write_checker #(.AW(16), .DW(16), .NCHK(2), .TIMEOUT(16), .ORDERED(1)) dut_o (
        .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
        .pass(pass_w[0]), .fail(fail_w[0]), .done(done_w[0]), .fail_code(code_w[0]),
        .match_cnt(mcnt_w[0]), .write_cnt(wcnt_w[0]), .fail_adr(fadr_w[0]), .fail_data(fdata_w[0])
    );

    mem_write_checker #(.AW(16), .DW(16), .NCHK(2), .TIMEOUT(16), .ORDERED(0)) dut_u (
        .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
        .pass(pass_w[1]), .fail(fail_w[1]), .done(done_w[1]), .fail_code(code_w[1]),
        .match_cnt(mcnt_w[1]), .write_cnt(wcnt_w[1]), .fail_adr(fadr_w[1]), .fail_data(fdata_w[1])
    );

    mem_write_checker #(.AW(16), .DW(16), .NCHK(1), .TIMEOUT(16), .ORDERED(1)) dut_s (
        .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
        .pass(pass_w[2]), .fail(fail_w[2]), .done(done_w[2]), .fail_code(code_w[2]),
        .match_cnt(mcnt_w[2]), .write_cnt(wcnt_w[2]), .fail_adr(fadr_w[2]), .fail_data(fdata_w[2])
    );

    task automatic cmp(input string nm, input int d, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, expv, $time);
        end
    endtask

    task automatic push(input int d, input int p, input int f, input int code, input int mcnt,
                        input int wcnt, input int fadr, input int fdata, input int at);
        rec_t r;
        r.p = p; r.f = f; r.code = code; r.mcnt = mcnt;
        r.wcnt = wcnt; r.fadr = fadr; r.fdata = fdata; r.at = at;
        exp_q[d].push_back(r);
    endtask

    task automatic push_all(input int p, input int f, input int code, input int mcnt,
                            input int wcnt, input int fadr, input int fdata, input int at);
        for (int d = 0; d < 3; d++) push(d, p, f, code, mcnt, wcnt, fadr, fdata, at);
    endtask

    // Monitor: on a rising done or a snapshot request, pop the next expectation and compare
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if ((done_w[d] === 1'b1 && !done_prev[d]) || snap) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d: got done=%0d expected no event (t=%0t)",
                                 d, done_w[d], $time);
                    end else begin
                        r = exp_q[d].pop_front();
                        cmp("pass", d, int'(pass_w[d]), r.p);
                        cmp("fail", d, int'(fail_w[d]), r.f);
                        cmp("done", d, int'(done_w[d]), r.p | r.f);
                        cmp("fail_code", d, int'(code_w[d]), r.code);
                        cmp("match_cnt", d, int'(mcnt_w[d]), r.mcnt);
                        cmp("write_cnt", d, int'(wcnt_w[d]), r.wcnt);
                        cmp("fail_adr", d, int'(fadr_w[d]), r.fadr);
                        cmp("fail_data", d, int'(fdata_w[d]), r.fdata);
                        if (r.at >= 0) cmp("verdict_cycle", d, cyc, r.at);
                    end
                end
                done_prev[d] = (done_w[d] === 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        memwrite = 1'b1; adr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic load(input logic [0:0] i, input logic [15:0] a, input logic [15:0] d);
        exp_we = 1'b1; exp_idx = i; exp_adr = a; exp_data = d;
        step();
        exp_we = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        step();
        snap = 1'b0;
    endtask

    initial begin
        int s;
        reset = 1'b0; memwrite = 1'b0; adr = 16'd0; writedata = 16'd0;
        exp_we = 1'b0; exp_idx = 1'b0; exp_adr = 16'd0; exp_data = 16'd0;
        start = 1'b0; snap = 1'b0;
        step(); step();
        push_all(0, 0, 0, 0, 0, 0, 0, -1);
        do_snap();
        reset = 1'b1;
        step();

        // A: ordered vs unordered vs single entry; entry1 loaded in the start cycle
        load(1'b0, 16'd4, 16'd1);
        exp_we = 1'b1; exp_idx = 1'b1; exp_adr = 16'd8; exp_data = 16'd2; start = 1'b1;
        step();
        exp_we = 1'b0; start = 1'b0; s = cyc;
        push(0, 1, 0, 0, 2, 3, 0, 0, s + 3);
        push(1, 1, 0, 0, 2, 2, 0, 0, s + 2);
        push(2, 1, 0, 0, 1, 2, 0, 0, s + 2);
        wr(16'd8, 16'd2); wr(16'd4, 16'd1); wr(16'd8, 16'd2);
        repeat (3) step();

        // B: data mismatch on an expected address, verdict stays sticky afterwards
        start = 1'b1; step(); start = 1'b0; s = cyc;
        push_all(0, 1, 1, 0, 1, 4, 7, s + 1);
        wr(16'd4, 16'd7); wr(16'd4, 16'd1); wr(16'd8, 16'd2);
        step();
        push_all(0, 1, 1, 0, 1, 4, 7, -1);
        do_snap();

        // C: a repeat write to an already-matched address is ignored
        start = 1'b1; step(); start = 1'b0; s = cyc;
        push(0, 1, 0, 0, 2, 3, 0, 0, s + 3);
        push(1, 1, 0, 0, 2, 3, 0, 0, s + 3);
        push(2, 1, 0, 0, 1, 1, 0, 0, s + 1);
        wr(16'd4, 16'd1); wr(16'd4, 16'd9); wr(16'd8, 16'd2);
        repeat (2) step();

        // D: no writes -> timeout exactly 16 cycles after start is sampled
        start = 1'b1; step(); start = 1'b0; s = cyc;
        push_all(0, 1, 2, 0, 0, 0, 0, s + 16);
        while (cyc < s + 19) step();

        // E: final match on the last allowed cycle wins; a table load during RUN is ignored
        start = 1'b1; step(); start = 1'b0; s = cyc;
        push(0, 1, 0, 0, 2, 2, 0, 0, s + 16);
        push(1, 1, 0, 0, 2, 2, 0, 0, s + 16);
        push(2, 1, 0, 0, 1, 1, 0, 0, s + 1);
        wr(16'd4, 16'd1);
        load(1'b1, 16'd8, 16'd3);
        while (cyc < s + 15) step();
        wr(16'd8, 16'd2);
        repeat (3) step();

        // F: mid-run reset clears outputs and table; a write in the start cycle is not checked
        start = 1'b1; step(); start = 1'b0; s = cyc;
        push(2, 1, 0, 0, 1, 1, 0, 0, s + 1);
        wr(16'd4, 16'd1);
        step();
        reset = 1'b0; step(); reset = 1'b1;
        push_all(0, 0, 0, 0, 0, 0, 0, -1);
        do_snap();
        start = 1'b1; memwrite = 1'b1; adr = 16'd0; writedata = 16'd5;
        step();
        start = 1'b0; s = cyc;
        push_all(0, 1, 1, 0, 1, 0, 5, s + 1);
        step();
        memwrite = 1'b0;
        repeat (4) step();

        for (int d = 0; d < 3; d++) cmp("pending_expectations", d, exp_q[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
